// File: rtl/sobel_stream.sv
// sobel_stream: streaming 3x3 Sobel edge detector for RGB video.
//
// Converts every accepted {R,G,B} pixel to grayscale, keeps the two previous
// lines in line RAMs and emits one edge pixel per input pixel. Output pixel
// (r,c) is the Sobel response centred on input (r-1,c-1); rows 0-1 and
// columns 0-1 are forced to zero. The whole pipeline stalls on a single
// enable, so no pixel is lost or duplicated under backpressure.
//
// Ports
//   clk, rst_n       clock, asynchronous active-low reset
//   s_valid/s_ready  input handshake, pixel accepted when both are high
//   s_data           input pixel {R,G,B}, CH_W bits per channel
//   s_sof, s_eol     first pixel of frame, last pixel of line
//   m_valid/m_ready  output handshake
//   m_data           edge value replicated on R,G,B
//   m_sof, m_eol     input sidebands delayed with their pixel
//   mode             00 |Gx|+|Gy|, 01 |Gx|, 10 |Gy|, 11 binary against thresh
//   thresh           binary-mode threshold, sampled every cycle
//   err              sticky line-length error, cleared only by reset
module sobel_stream #(
   parameter int IMG_W     = 1280,
   parameter int IMG_H     = 720,
   parameter int CH_W      = 8,
   parameter int MAG_SHIFT = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [3*CH_W-1:0] s_data,
   input  logic              s_sof,
   input  logic              s_eol,
   output logic              m_valid,
   input  logic              m_ready,
   output logic [3*CH_W-1:0] m_data,
   output logic              m_sof,
   output logic              m_eol,
   input  logic [1:0]        mode,
   input  logic [CH_W-1:0]   thresh,
   output logic              err
);

   localparam int CW = IMG_W > 4 ? $clog2(IMG_W) : 2;
   localparam int RW = IMG_H > 4 ? $clog2(IMG_H) : 2;
   localparam int GW = CH_W + 4;
   localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

   function automatic logic signed [GW-1:0] ext(input logic [CH_W-1:0] x);
      ext = $signed({{(GW-CH_W){1'b0}}, x});
   endfunction

   logic ce;
   logic rdy;
   logic accept;

   // input decode and position tracking
   logic [CH_W-1:0] r_in;
   logic [CH_W-1:0] g_in;
   logic [CH_W-1:0] b_in;
   logic [CH_W+1:0] gsum;
   logic [CH_W-1:0] gray_in;
   logic [CW-1:0]   col;
   logic [CW-1:0]   cur_col;
   logic [RW-1:0]   row;
   logic [RW-1:0]   cur_row;
   logic            line_end;
   logic            len_err;
   logic [1:0]      mode_q;
   logic [1:0]      pix_mode;

   // stage 0: accepted pixel
   logic            v0;
   logic [CH_W-1:0] g0;
   logic [CW-1:0]   c0;
   logic [RW-1:0]   r0;
   logic            sof0;
   logic            eol0;
   logic [1:0]      md0;

   // stage 1: column vector {bottom, middle, top} from the line RAMs
   logic                     v1;
   logic [2:0][CH_W-1:0]     colv1;
   logic [CW-1:0]            c1;
   logic [RW-1:0]            r1;
   logic                     sof1;
   logic                     eol1;
   logic [1:0]               md1;
   logic [CH_W-1:0]          ram1 [IMG_W];
   logic [CH_W-1:0]          ram2 [IMG_W];

   // stage 2: 3x3 window, win[x][y], x=0 left, y=0 top
   logic                     v2;
   logic [2:0][2:0][CH_W-1:0] win;
   logic [CW-1:0]            c2;
   logic [RW-1:0]            r2;
   logic                     sof2;
   logic                     eol2;
   logic [1:0]               md2;
   logic signed [GW-1:0]     gx_c;
   logic signed [GW-1:0]     gy_c;
   logic                     bord_c;

   // stage 3: gradients
   logic                     v3;
   logic signed [GW-1:0]     gx3;
   logic signed [GW-1:0]     gy3;
   logic                     bord3;
   logic                     sof3;
   logic                     eol3;
   logic [1:0]               md3;

   // stage 4 combinational result
   logic [GW-1:0]   ax;
   logic [GW-1:0]   ay;
   logic [GW:0]     sum;
   logic [GW:0]     sel;
   logic [GW:0]     sel_sh;
   logic [GW:0]     sum_sh;
   logic [CH_W-1:0] mag;
   logic            hit;
   logic [CH_W-1:0] pix_out;

   // rdy keeps s_ready low while in reset and rises on the first edge after release
   assign ce      = ~m_valid | m_ready;
   assign s_ready = rdy & ce;
   assign accept  = s_valid & s_ready;

   always_comb begin
      r_in     = s_data[3*CH_W-1 -: CH_W];
      g_in     = s_data[2*CH_W-1 -: CH_W];
      b_in     = s_data[CH_W-1:0];
      gsum     = {2'b00, r_in} + {1'b0, g_in, 1'b0} + {2'b00, b_in};
      gray_in  = gsum[CH_W+1:2];
      cur_col  = s_sof ? '0 : col;
      cur_row  = s_sof ? '0 : row;
      // an early s_eol and a missing s_eol on the last column both end the line and flag an error
      line_end = s_eol | (cur_col == COL_LAST);
      len_err  = s_eol ^ (cur_col == COL_LAST);
      pix_mode = s_sof ? mode : mode_q;
   end

   always_comb begin
      gx_c   = (ext(win[2][0]) + (ext(win[2][1]) <<< 1) + ext(win[2][2]))
             - (ext(win[0][0]) + (ext(win[0][1]) <<< 1) + ext(win[0][2]));
      gy_c   = (ext(win[0][2]) + (ext(win[1][2]) <<< 1) + ext(win[2][2]))
             - (ext(win[0][0]) + (ext(win[1][0]) <<< 1) + ext(win[2][0]));
      bord_c = ~|r2[RW-1:1] | ~|c2[CW-1:1];
   end

   always_comb begin
      ax      = gx3[GW-1] ? GW'(-gx3) : GW'(gx3);
      ay      = gy3[GW-1] ? GW'(-gy3) : GW'(gy3);
      sum     = {1'b0, ax} + {1'b0, ay};
      sel     = md3 == 2'd1 ? {1'b0, ax} : md3 == 2'd2 ? {1'b0, ay} : sum;
      sel_sh  = sel >> MAG_SHIFT;
      sum_sh  = sum >> MAG_SHIFT;
      mag     = |sel_sh[GW:CH_W] ? '1 : sel_sh[CH_W-1:0];
      hit     = sum_sh >= {{(GW+1-CH_W){1'b0}}, thresh};
      pix_out = bord3 ? '0 : md3 == 2'd3 ? {CH_W{hit}} : mag;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdy     <= 1'b0;
         col     <= '0;
         row     <= '0;
         mode_q  <= '0;
         err     <= 1'b0;
         v0      <= 1'b0;
         v1      <= 1'b0;
         v2      <= 1'b0;
         v3      <= 1'b0;
         m_valid <= 1'b0;
         m_data  <= '0;
         m_sof   <= 1'b0;
         m_eol   <= 1'b0;
      end else begin
         rdy <= 1'b1;
         if (accept) begin
            col    <= line_end ? '0 : cur_col + 1'b1;
            row    <= line_end ? (cur_row == ROW_LAST ? cur_row : cur_row + 1'b1) : cur_row;
            mode_q <= pix_mode;
            err    <= err | len_err;
         end
         if (ce) begin
            v0      <= accept;
            v1      <= v0;
            v2      <= v1;
            v3      <= v2;
            m_valid <= v3;
            if (v3) begin
               m_data <= {3{pix_out}};
               m_sof  <= sof3;
               m_eol  <= eol3;
            end
         end
      end
   end

   // datapath and line RAMs carry no reset; stale RAM contents only reach masked border pixels
   always_ff @(posedge clk) begin
      if (accept) begin
         g0   <= gray_in;
         c0   <= cur_col;
         r0   <= cur_row;
         sof0 <= s_sof;
         eol0 <= s_eol;
         md0  <= pix_mode;
      end
      if (ce && v0) begin
         colv1    <= {g0, ram1[c0], ram2[c0]};
         ram1[c0] <= g0;
         ram2[c0] <= ram1[c0];
         c1       <= c0;
         r1       <= r0;
         sof1     <= sof0;
         eol1     <= eol0;
         md1      <= md0;
      end
      // the window shifts only on real pixels so bubbles never enter it
      if (ce && v1) begin
         win  <= {colv1, win[2], win[1]};
         c2   <= c1;
         r2   <= r1;
         sof2 <= sof1;
         eol2 <= eol1;
         md2  <= md1;
      end
      if (ce && v2) begin
         gx3   <= gx_c;
         gy3   <= gy_c;
         bord3 <= bord_c;
         sof3  <= sof2;
         eol3  <= eol2;
         md3   <= md2;
      end
   end

endmodule

// File: tb/tb_sobel_stream.sv
// tb_sobel_stream: directed self-checking bench for sobel_stream on an 8x6 frame.
module tb_sobel_stream;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        s_valid = 1'b0;
   logic        s_ready;
   logic [23:0] s_data = '0;
   logic        s_sof = 1'b0;
   logic        s_eol = 1'b0;
   logic        m_valid;
   logic        m_ready = 1'b1;
   logic [23:0] m_data;
   logic        m_sof;
   logic        m_eol;
   logic [1:0]  mode = 2'd0;
   logic [7:0]  thresh = '0;
   logic        err;

   int checks = 0;
   int failures = 0;
   int bp_viol = 0;
   bit bp_en = 1'b0;
   logic [25:0] q[$];

   sobel_stream #(.IMG_W(8), .IMG_H(6), .CH_W(8), .MAG_SHIFT(0)) dut (
      .clk(clk), .rst_n(rst_n),
      .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_sof(s_sof), .s_eol(s_eol),
      .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_sof(m_sof), .m_eol(m_eol),
      .mode(mode), .thresh(thresh), .err(err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      #1 m_ready = bp_en ? ($urandom_range(0, 2) != 0) : 1'b1;
   end

   always @(negedge clk) begin
      if (rst_n) begin
         if (m_valid && m_ready) q.push_back({m_sof, m_eol, m_data});
         if (m_valid && !m_ready && s_ready) bp_viol++;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   function automatic logic [23:0] pix(input int kind, input int c);
      return kind == 0 ? 24'h808080 : kind == 1 ? (c >= 4 ? 24'hFFFFFF : 24'h0) : (c >= 4 ? 24'h141414 : 24'h0);
   endfunction

   task automatic send(input logic [23:0] d, input logic sof, input logic eol, input int gap);
      int n = 0;
      repeat (gap) begin
         @(negedge clk);
         s_valid = 1'b0;
      end
      @(negedge clk);
      s_valid = 1'b1;
      s_data  = d;
      s_sof   = sof;
      s_eol   = eol;
      while (!s_ready && n < 500) begin
         @(negedge clk);
         n++;
      end
      if (n >= 500) begin
         checks++;
         failures++;
         $display("FAIL send_timeout s_ready=%b required=1", s_ready);
      end
      @(posedge clk);
   endtask

   task automatic send_frame(input int kind, input bit gaps);
      for (int r = 0; r < 6; r++)
         for (int c = 0; c < 8; c++)
            send(pix(kind, c), r == 0 && c == 0, c == 7, gaps ? int'($urandom_range(0, 2)) : 0);
      @(negedge clk);
      s_valid = 1'b0;
      s_sof   = 1'b0;
      s_eol   = 1'b0;
   endtask

   task automatic wait_out(input int n);
      int t = 0;
      while (q.size() < n && t < 3000) begin
         @(negedge clk);
         t++;
      end
      repeat (8) @(negedge clk);
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({m_valid, m_sof, m_eol, err, m_data} !== 28'h0) begin
         failures++;
         $display("FAIL reset_outputs got=%h required=0", {m_valid, m_sof, m_eol, err, m_data});
      end
      checks++;
      if (s_ready !== 1'b0) begin
         failures++;
         $display("FAIL reset_s_ready got=%b required=0", s_ready);
      end
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (s_ready !== 1'b1) begin
         failures++;
         $display("FAIL release_s_ready got=%b required=1", s_ready);
      end
   endtask

   task automatic test_flat;
      int b = q.size();
      mode = 2'd0;
      send_frame(0, 0);
      wait_out(b + 48);
      checks++;
      if (q.size() - b !== 48) begin
         failures++;
         $display("FAIL flat_count got=%0d required=48", q.size() - b);
      end
      for (int i = 0; i < 48 && b + i < q.size(); i++) begin
         checks++;
         if (q[b+i] !== {i == 0, i % 8 == 7, 24'h0}) begin
            failures++;
            $display("FAIL flat_pix%0d got=%h required=%h", i, q[b+i], {i == 0, i % 8 == 7, 24'h0});
         end
      end
      checks++;
      if (err !== 1'b0) begin
         failures++;
         $display("FAIL flat_err got=%b required=0", err);
      end
   endtask

   task automatic test_half;
      for (int m = 1; m <= 2; m++) begin
         int b = q.size();
         mode = 2'(m);
         send_frame(1, 0);
         wait_out(b + 48);
         checks++;
         if (q.size() - b !== 48) begin
            failures++;
            $display("FAIL half_count mode=%0d got=%0d required=48", m, q.size() - b);
         end
         for (int i = 0; i < 48 && b + i < q.size(); i++) begin
            logic [23:0] e = (m == 1 && i / 8 >= 2 && (i % 8 == 4 || i % 8 == 5)) ? 24'hFFFFFF : 24'h0;
            checks++;
            if (q[b+i][23:0] !== e) begin
               failures++;
               $display("FAIL half_pix mode=%0d i=%0d got=%h required=%h", m, i, q[b+i][23:0], e);
            end
         end
      end
   endtask

   task automatic test_step;
      logic [23:0] hi [3] = '{24'h505050, 24'h000000, 24'hFFFFFF};
      logic [7:0]  th [3] = '{8'd0, 8'd100, 8'd80};
      for (int k = 0; k < 3; k++) begin
         int b = q.size();
         mode   = k == 0 ? 2'd0 : 2'd3;
         thresh = th[k];
         send_frame(2, 0);
         wait_out(b + 48);
         checks++;
         if (q.size() - b !== 48) begin
            failures++;
            $display("FAIL step_count k=%0d got=%0d required=48", k, q.size() - b);
         end
         for (int i = 0; i < 48 && b + i < q.size(); i++) begin
            logic [23:0] e = (i / 8 >= 2 && (i % 8 == 4 || i % 8 == 5)) ? hi[k] : 24'h0;
            checks++;
            if (q[b+i][23:0] !== e) begin
               failures++;
               $display("FAIL step_pix k=%0d i=%0d got=%h required=%h", k, i, q[b+i][23:0], e);
            end
         end
      end
   endtask

   task automatic test_backpressure;
      int b = q.size();
      int v = bp_viol;
      mode  = 2'd1;
      bp_en = 1'b1;
      send_frame(1, 1);
      wait_out(b + 48);
      bp_en = 1'b0;
      repeat (4) @(negedge clk);
      checks++;
      if (q.size() - b !== 48) begin
         failures++;
         $display("FAIL bp_count got=%0d required=48", q.size() - b);
      end
      for (int i = 0; i < 48 && b + i < q.size(); i++) begin
         logic [25:0] e = {i == 0, i % 8 == 7, (i / 8 >= 2 && (i % 8 == 4 || i % 8 == 5)) ? 24'hFFFFFF : 24'h0};
         checks++;
         if (q[b+i] !== e) begin
            failures++;
            $display("FAIL bp_pix i=%0d got=%h required=%h", i, q[b+i], e);
         end
      end
      checks++;
      if (bp_viol !== v) begin
         failures++;
         $display("FAIL bp_s_ready_while_stalled got=%0d required=0", bp_viol - v);
      end
   endtask

   task automatic test_latency;
      int b = q.size();
      @(negedge clk);
      mode    = 2'd0;
      s_valid = 1'b1;
      s_data  = 24'h123456;
      s_sof   = 1'b1;
      s_eol   = 1'b0;
      checks++;
      if (s_ready !== 1'b1) begin
         failures++;
         $display("FAIL lat_s_ready got=%b required=1", s_ready);
      end
      @(posedge clk);
      #1;
      checks++;
      if (m_valid !== 1'b0) begin
         failures++;
         $display("FAIL lat_edge0 m_valid got=%b required=0", m_valid);
      end
      @(negedge clk);
      s_valid = 1'b0;
      s_sof   = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         @(posedge clk);
         #1;
         checks++;
         if (m_valid !== (k == 4)) begin
            failures++;
            $display("FAIL lat_edge%0d m_valid got=%b required=%b", k, m_valid, k == 4);
         end
      end
      repeat (4) @(negedge clk);
      checks++;
      if (q.size() - b !== 1) begin
         failures++;
         $display("FAIL lat_count got=%0d required=1", q.size() - b);
      end
   endtask

   task automatic test_err;
      int b = q.size();
      mode = 2'd1;
      checks++;
      if (err !== 1'b0) begin
         failures++;
         $display("FAIL err_pre got=%b required=0", err);
      end
      for (int c = 0; c < 6; c++) send(pix(1, c), c == 0, c == 5, 0);
      @(negedge clk);
      s_valid = 1'b0;
      s_sof   = 1'b0;
      s_eol   = 1'b0;
      checks++;
      if (err !== 1'b1) begin
         failures++;
         $display("FAIL err_short_line got=%b required=1", err);
      end
      for (int r = 1; r < 3; r++)
         for (int c = 0; c < 8; c++) send(pix(1, c), 1'b0, c == 7, 0);
      @(negedge clk);
      s_valid = 1'b0;
      s_eol   = 1'b0;
      wait_out(b + 22);
      checks++;
      if (q.size() - b !== 22) begin
         failures++;
         $display("FAIL err_count got=%0d required=22", q.size() - b);
      end
      if (q.size() - b >= 22) begin
         checks++;
         if (q[b+5][24] !== 1'b1) begin
            failures++;
            $display("FAIL err_short_eol got=%b required=1", q[b+5][24]);
         end
         checks++;
         if (q[b+17][23:0] !== 24'h0) begin
            failures++;
            $display("FAIL resync_c3 got=%h required=000000", q[b+17][23:0]);
         end
         checks++;
         if (q[b+18][23:0] !== 24'hFFFFFF) begin
            failures++;
            $display("FAIL resync_c4 got=%h required=ffffff", q[b+18][23:0]);
         end
         checks++;
         if (q[b+19][23:0] !== 24'hFFFFFF) begin
            failures++;
            $display("FAIL resync_c5 got=%h required=ffffff", q[b+19][23:0]);
         end
      end
      send(pix(1, 0), 1'b0, 1'b0, 0);
      send(pix(1, 1), 1'b0, 1'b0, 0);
      @(negedge clk);
      rst_n   = 1'b0;
      s_valid = 1'b0;
      @(negedge clk);
      checks++;
      if ({m_valid, err, s_ready} !== 3'b000) begin
         failures++;
         $display("FAIL midreset got m_valid,err,s_ready=%b required=000", {m_valid, err, s_ready});
      end
      @(negedge clk);
      rst_n = 1'b1;
      b = q.size();
      @(posedge clk);
      #1;
      checks++;
      if ({s_ready, m_valid, err} !== 3'b100) begin
         failures++;
         $display("FAIL midreset_release got s_ready,m_valid,err=%b required=100", {s_ready, m_valid, err});
      end
      mode = 2'd1;
      send_frame(1, 0);
      wait_out(b + 48);
      checks++;
      if (q.size() - b !== 48) begin
         failures++;
         $display("FAIL recover_count got=%0d required=48", q.size() - b);
      end
      if (q.size() - b >= 48) begin
         checks++;
         if (q[b][25] !== 1'b1 || q[b+20][23:0] !== 24'hFFFFFF) begin
            failures++;
            $display("FAIL recover_pix got sof=%b c4=%h required sof=1 c4=ffffff", q[b][25], q[b+20][23:0]);
         end
      end
   endtask

   initial begin
      test_reset;
      test_flat;
      test_half;
      test_step;
      test_backpressure;
      test_latency;
      test_err;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
